// File: rtl/ddr4_rx_lane_align.sv
// Read-side training for one DDR4 DQ lane in 4:1 receive mode: finds word alignment
// with bit slips, sweeps the delay line across the data eye and parks it at the centre.
module ddr4_rx_lane_align #(
  parameter logic [3:0] PATTERN = 4'b0011,
  parameter int         WINDOW  = 16,
  parameter int         SETTLE  = 8,
  parameter int         TAP_MAX = 127,
  parameter int         MIN_EYE = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       TRAIN_START,
  input  logic [3:0] RX_DATA,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       RX_BIT_SLIP,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [7:0] CENTER_TAP,
  output logic [7:0] EYE_WIDTH,
  output logic [1:0] SLIP_COUNT
);

  localparam int         TMR_W     = $clog2((WINDOW > SETTLE) ? WINDOW : SETTLE);
  localparam logic [7:0] TAP_MAX_W = 8'(TAP_MAX);
  localparam logic [8:0] MIN_EYE_W = 9'(MIN_EYE);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK_ALIGN, S_SLIP, S_STEP_ALIGN,
    S_STEP_SWEEP, S_CHECK_SWEEP, S_EVAL, S_CENTER, S_DONE, S_FAIL
  } state_t;

  // where the settle period hands off once it expires
  typedef enum logic [1:0] {P_ALIGN, P_SWEEP, P_STEP, P_FINISH} pend_t;

  state_t st_q, st_d;
  pend_t  pend_q, pend_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0] tap_q, tap_d, first_q, first_d, last_q, last_d;
  logic [7:0] center_q, center_d, width_q, width_d;
  logic [7:0] ctap_q, ctap_d, ewid_q, ewid_d;
  logic [1:0] tries_q, tries_d, slips_q, slips_d;
  logic       up_q, up_d, phase_q, phase_d, dir_q, dir_d;
  logic       busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [7:0] span;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      st_q <= S_IDLE;      pend_q <= P_ALIGN;   tmr_q <= '0;
      tap_q <= '0;         first_q <= '0;       last_q <= '0;
      center_q <= '0;      width_q <= '0;       ctap_q <= '0;
      ewid_q <= '0;        tries_q <= '0;       slips_q <= '0;
      up_q <= 1'b0;        phase_q <= 1'b0;     dir_q <= 1'b0;
      busy_q <= 1'b0;      done_q <= 1'b0;      fail_q <= 1'b0;
    end else begin
      st_q <= st_d;        pend_q <= pend_d;    tmr_q <= tmr_d;
      tap_q <= tap_d;      first_q <= first_d;  last_q <= last_d;
      center_q <= center_d; width_q <= width_d; ctap_q <= ctap_d;
      ewid_q <= ewid_d;    tries_q <= tries_d;  slips_q <= slips_d;
      up_q <= up_d;        phase_q <= phase_d;  dir_q <= dir_d;
      busy_q <= busy_d;    done_q <= done_d;    fail_q <= fail_d;
    end
  end

  always_comb begin
    st_d = st_q;         pend_d = pend_q;     tmr_d = tmr_q;
    tap_d = tap_q;       first_d = first_q;   last_d = last_q;
    center_d = center_q; width_d = width_q;   ctap_d = ctap_q;
    ewid_d = ewid_q;     tries_d = tries_q;   slips_d = slips_q;
    up_d = up_q;         phase_d = phase_q;   dir_d = dir_q;
    busy_d = busy_q;     done_d = done_q;     fail_d = fail_q;
    RX_BIT_SLIP = 1'b0;
    DELAY_LINE_LOAD = 1'b0;
    DELAY_LINE_MOVE = 1'b0;
    span = last_q - first_q;

    case (st_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (TRAIN_START) begin
          st_d = S_LOAD;   busy_d = 1'b1; done_d = 1'b0; fail_d = 1'b0;
          ctap_d = '0;     ewid_d = '0;   slips_d = '0;
        end
      end
      S_LOAD: begin
        DELAY_LINE_LOAD = 1'b1;
        tap_d = '0;  tries_d = '0;  up_d = 1'b0;
        pend_d = P_ALIGN;
        tmr_d = TMR_W'(SETTLE - 1);
        st_d = S_SETTLE;
      end
      S_SETTLE: begin
        // a limit flag after an increment means the line stayed put
        if (up_q && DELAY_LINE_OUT_OF_RANGE) begin
          tap_d = tap_q - 8'd1;
          up_d = 1'b0;
          st_d = (pend_q == P_SWEEP) ? S_EVAL : S_FAIL;
        end else if (tmr_q == '0) begin
          up_d = 1'b0;
          tmr_d = TMR_W'(WINDOW - 1);
          case (pend_q)
            P_ALIGN: st_d = S_CHECK_ALIGN;
            P_SWEEP: st_d = S_CHECK_SWEEP;
            P_STEP:  st_d = S_STEP_ALIGN;
            default: st_d = S_DONE;
          endcase
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_CHECK_ALIGN: begin
        if (RX_DATA != PATTERN) begin
          // the fourth slip brings the rotation back to where this tap started
          pend_d = (tries_q == 2'd3) ? P_STEP : P_ALIGN;
          tries_d = tries_q + 2'd1;
          st_d = S_SLIP;
        end else if (tmr_q == '0) begin
          first_d = tap_q;
          last_d = tap_q;
          st_d = S_STEP_SWEEP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SLIP: begin
        RX_BIT_SLIP = 1'b1;
        slips_d = slips_q + 2'd1;
        tmr_d = TMR_W'(SETTLE - 1);
        st_d = S_SETTLE;
      end
      S_STEP_ALIGN, S_STEP_SWEEP: begin
        if (tap_q == TAP_MAX_W) begin
          st_d = (st_q == S_STEP_ALIGN) ? S_FAIL : S_EVAL;
        end else begin
          DELAY_LINE_MOVE = 1'b1;
          dir_d = 1'b1;
          tap_d = tap_q + 8'd1;
          up_d = 1'b1;
          pend_d = (st_q == S_STEP_ALIGN) ? P_ALIGN : P_SWEEP;
          tmr_d = TMR_W'(SETTLE - 1);
          st_d = S_SETTLE;
        end
      end
      S_CHECK_SWEEP: begin
        if (RX_DATA != PATTERN) begin
          st_d = S_EVAL;
        end else if (tmr_q == '0) begin
          last_d = tap_q;
          st_d = S_STEP_SWEEP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_EVAL: begin
        if (({1'b0, span} + 9'd1) < MIN_EYE_W) begin
          st_d = S_FAIL;
        end else begin
          width_d = span + 8'd1;
          center_d = first_q + (span >> 1);
          phase_d = 1'b0;
          st_d = S_CENTER;
        end
      end
      S_CENTER: begin
        if (tap_q > center_q) begin
          if (!phase_q) begin
            DELAY_LINE_MOVE = 1'b1;
            dir_d = 1'b0;
            tap_d = tap_q - 8'd1;
          end
          phase_d = ~phase_q;
        end else begin
          pend_d = P_FINISH;
          tmr_d = TMR_W'(SETTLE - 1);
          st_d = S_SETTLE;
        end
      end
      default: st_d = S_IDLE;
    endcase

    if (st_d == S_DONE && st_q != S_DONE) begin
      done_d = 1'b1; busy_d = 1'b0; ctap_d = tap_d; ewid_d = width_q;
    end
    if (st_d == S_FAIL && st_q != S_FAIL) begin
      fail_d = 1'b1; busy_d = 1'b0; ctap_d = tap_d; ewid_d = '0;
    end
  end

  assign DELAY_LINE_DIRECTION = dir_d;
  assign TRAIN_BUSY = busy_q;
  assign TRAIN_DONE = done_q;
  assign TRAIN_FAIL = fail_q;
  assign CENTER_TAP = ctap_q;
  assign EYE_WIDTH  = ewid_q;
  assign SLIP_COUNT = slips_q;

endmodule
